// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the multiplexed hex display driver:
// segment encodings, the nibble-to-segment function and width helpers.
package hex_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-high abcdefg (bit6=a ... bit0=g) for hex digits 0..F.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam int N_DIGITS_DEFAULT = 4;

    // $clog2 with a floor of 1 so single-entry counters still get a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(N_DIGITS_DEFAULT);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return ~SEG_PATTERN[nibble];
    endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational nibble to active-low 7-segment lookup.
module hex7seg_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed N-digit common-anode hex display driver with a double-buffered value.
// Optional leading-zero blanking: define HEX_DISPLAY_LZ_BLANK_EN.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int VW = 4 * N_DIGITS;
    localparam int IW = idx_width(N_DIGITS);
    localparam int CW = idx_width(REFRESH_DIV);
    localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [VW-1:0]       shadow_q;
    logic [VW-1:0]       active_q;
    logic                pending_q;
    logic                tick;
    logic                frame_end;
    logic [VW-1:0]       upper;
    logic [6:0]          cur_seg;
    logic [N_DIGITS-1:0] an_d;
    logic                lz_blank;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end
    end

    // A load landing on frame_end goes straight to active so it is not lost
    // for a whole extra frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else if (load) begin
            shadow_q <= value;
            if (frame_end) begin
                active_q  <= value;
                pending_q <= 1'b0;
            end else begin
                pending_q <= 1'b1;
            end
        end else if (frame_end && pending_q) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
        end
    end

    // upper holds the current digit and all more significant digits.
    assign upper = active_q >> {idx_q, 2'b00};
    assign an_d  = ~(AN_ONE << idx_q);

    hex7seg_lut u_lut (
        .nibble (upper[3:0]),
        .seg    (cur_seg)
    );

    always_comb begin
        lz_blank = 1'b0;
`ifdef HEX_DISPLAY_LZ_BLANK_EN
        lz_blank = (idx_q != '0) && (upper == '0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (blank) begin
                seg <= SEG_OFF;
                an  <= '1;
            end else begin
                seg <= lz_blank ? SEG_OFF : cur_seg;
                an  <= an_d;
            end
        end
    end

endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed hex value and scans one digit per refresh period.
- Each digit is decoded 0-F to active-low segments, and the matching digit enable is driven active-low.
- It is the sequential successor to the single-digit combinational decoder and sits between the datapath and the board display pins.
- Values are double-buffered, so an update never tears mid-frame.

Parameters:
- N_DIGITS, 4: number of digits scanned; range 1..8.
- REFRESH_DIV, 50000: clock cycles each digit stays lit; must be at least 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- value, input, 4*N_DIGITS: packed hex value; nibble k (bits 4k+3:4k) is digit k, digit 0 is the least significant.
- load, input, 1: single-cycle strobe that captures value into the shadow register.
- blank, input, 1: forces all segments and all digit enables off while high.
- seg, output, 7: active-low segments, bit6=a … bit0=g.
- an, output, N_DIGITS: active-low one-hot digit enable; an[k] selects digit k.
- frame_done, output, 1: one-cycle pulse when the last digit's period ends.

Behaviour:
- Reset, asynchronous and applied immediately:
  - divider count = 0, digit index = 0;
  - shadow register = 0, active register = 0, pending = 0;
  - seg = 7'b1111111, an = all ones, frame_done = 0.
- Divider:
  - Counts 0..REFRESH_DIV-1.
  - tick is asserted in the cycle where count == REFRESH_DIV-1; count then wraps to 0.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index:
  - Advances on tick, wrapping from N_DIGITS-1 to 0.
  - frame_end = tick AND index == N_DIGITS-1.
  - frame_done is registered: it is high in the cycle after frame_end.
- Load and buffering:
  - load: shadow <= value, pending <= 1.
  - On frame_end with pending=1: active <= shadow, pending <= 0.
  - load and frame_end in the same cycle: active <= value directly, shadow <= value, pending <= 0.
  - A load during a frame never changes the digits of that frame.
  - Repeated loads within one frame: the last one wins.
- Outputs:
  - seg and an are registered, with 1-cycle latency from the index/active state.
  - an = ~(1 << index).
  - seg = ~pattern(active nibble[index]).
- Active-high abcdefg patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- blank=1: seg and an are forced to all ones on the next edge. Scanning, loading and frame_done continue unaffected.
- Reset asserted mid-frame: all state clears immediately, including pending.
- Reset release: scanning restarts at digit 0 with count 0. The first clock edge shows an[0]=0 and seg=7'b0000001.

Optional Feature:
- Macro: HEX_DISPLAY_LZ_BLANK_EN.
- Defined:
  - A digit k>0 is blanked (seg all ones, its an still driven low) when nibble k and every higher nibble of active are zero.
  - Digit 0 is never blanked, so 0 displays as a single "0".
- Undefined: all digits are always shown, including leading zeros.

Decomposition:
- Package hex_display_pkg:
  - SEG_OFF = 7'h7F;
  - 16-entry active-high pattern constant array;
  - function hex_to_seg(nibble) returning the active-low segments;
  - localparam for the index width, $clog2(N_DIGITS) with a minimum of 1.
- One sub-module, hex7seg_lut: combinational nibble-to-segment lookup using the package function.
- The top module holds the divider, the index counter, the shadow/active buffering and the output registers.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, frame = 16 cycles):
- Reset then release; hold 20 cycles:
  - an cycles 1110→1101→1011→0111, each for 4 cycles;
  - seg = 7'b0000001 throughout;
  - frame_done pulses exactly once, the cycle after cycle 15.
- load=1 with value=16'h1234 at cycle 2:
  - frame 1 still shows all "0";
  - frame 2 shows an=1110/seg=~0110011 (4), an=1101/~1111001 (3), an=1011/~1101101 (2), an=0111/~0110000 (1).
- Loads 16'hABCD at cycle 5 and 16'hEF01 at cycle 9 within one frame: the next frame shows only EF01 (digit0=~0110000, digit3=~1001111).
- load of 16'h00F0 exactly on the frame_end cycle:
  - the next frame shows F0 immediately;
  - with HEX_DISPLAY_LZ_BLANK_EN, digits 2 and 3 show seg=7'h7F.
- blank=1 for 6 cycles mid-frame:
  - seg and an are all ones from the next edge;
  - scanning position is unaffected after release (correct an for the elapsed count).
- reset pulsed at cycle 7 of a frame after loading 16'h9999: outputs immediately return to 7'h7F/4'hF, and after release the display shows "0000".
